// File: rtl/spi_evt_pkg.sv
// Shared types and default constants for the SPI event reader.
// Holds the command FSM state encoding, the default command bytes and the STAT saturation helper.
package spi_evt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STAT  = 2'd1,
      ST_DATA  = 2'd2,
      ST_OTHER = 2'd3
   } state_t;

   localparam logic [7:0] SPI_CMD_READ  = 8'hF5;
   localparam logic [7:0] SPI_CMD_FLUSH = 8'hF6;
   localparam logic [7:0] SPI_FILL      = 8'hFF;

   // A full 256-entry FIFO cannot be reported in one byte, so clamp it.
   function automatic logic [7:0] sat8(input logic [8:0] v);
      return v[8] ? 8'hFF : v[7:0];
   endfunction

endpackage

// File: rtl/spi_evt_reader_fifo_sync.sv
// Synchronous byte FIFO (module fifo_sync) with push/pop/flush and a look-ahead head.
// o_head_next/o_empty_next give the head as it will be after this edge, so the reader can register it.
module fifo_sync #(
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push,
   input  logic [7:0]              i_wdata,
   input  logic                    i_pop,
   input  logic                    i_flush,
   output logic                    o_ready,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic [7:0]              o_head_next,
   output logic                    o_empty_next
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] w_rd_inc;
   logic [AW:0]   r_level;
   logic [AW:0]   w_level_next;
   logic          r_ready;
   logic          w_empty;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign w_empty   = (r_level == '0);
   assign w_push_ok = i_push & r_ready & ~i_flush;
   assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
   assign w_rd_inc  = r_rd_ptr + AW'(1);

   always_comb begin
      w_level_next = r_level;
      if (i_flush)
         w_level_next = '0;
      else if (w_push_ok && !w_pop_ok)
         w_level_next = r_level + (AW+1)'(1);
      else if (w_pop_ok && !w_push_ok)
         w_level_next = r_level - (AW+1)'(1);
   end

   // Head after this edge: a byte pushed into an empty (or emptying) FIFO becomes the head at once.
   always_comb begin
      o_head_next = r_mem[r_rd_ptr];
      if (w_pop_ok) begin
         if (r_level > (AW+1)'(1))
            o_head_next = r_mem[w_rd_inc];
         else
            o_head_next = i_wdata;
      end else if (w_empty) begin
         o_head_next = i_wdata;
      end
   end

   assign o_empty_next = (w_level_next == '0);

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ready  <= 1'b1;
      end else begin
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push_ok)
               r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)
               r_rd_ptr <= w_rd_inc;
         end
         r_level <= w_level_next;
         r_ready <= (w_level_next != FULL_LVL);
      end
   end

   assign o_level = r_level;
   assign o_ready = r_ready;

endmodule

// File: rtl/spi_evt_reader.sv
// Host-readable event queue: answers a read command with a level byte then queued event bytes.
// Define SPI_EVT_IRQ_EN to build the pending-data interrupt; otherwise irq is tied low.
module spi_evt_reader
   import spi_evt_pkg::*;
#(
   parameter int         DEPTH     = 16,
   parameter logic [7:0] CMD_READ  = SPI_CMD_READ,
   parameter logic [7:0] CMD_FLUSH = SPI_CMD_FLUSH,
   parameter logic [7:0] FILL      = SPI_FILL
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              pw_wdata,
   input  logic                    pw_wcmd,
   input  logic                    pw_wstb,
   input  logic                    pw_end,
   output logic [7:0]              usr_miso_data,
   input  logic                    usr_miso_ack,
   input  logic [7:0]              evt_data,
   input  logic                    evt_valid,
   output logic                    evt_ready,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    irq
);
   state_t                  r_state;
   state_t                  w_state_next;
   logic [7:0]              r_cmd;
   logic [7:0]              w_cmd_next;
   logic [7:0]              r_miso;
   logic [7:0]              w_miso_next;
   logic                    w_cmd_acc;
   logic                    w_pop;
   logic                    w_flush;
   logic [$clog2(DEPTH):0]  w_level;
   logic [7:0]              w_head_next;
   logic                    w_empty_next;
   logic                    w_ready;

   fifo_sync #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (evt_valid),
      .i_wdata      (evt_data),
      .i_pop        (w_pop),
      .i_flush      (w_flush),
      .o_ready      (w_ready),
      .o_level      (w_level),
      .o_head_next  (w_head_next),
      .o_empty_next (w_empty_next)
   );

   // CS rise takes priority over a command strobe landing in the same cycle.
   assign w_cmd_acc = pw_wstb & pw_wcmd & ~pw_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cmd   <= '0;
         r_miso  <= FILL;
      end else begin
         r_state <= w_state_next;
         r_cmd   <= w_cmd_next;
         r_miso  <= w_miso_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cmd_next   = r_cmd;
      if (pw_end) begin
         w_state_next = ST_IDLE;
      end else if (w_cmd_acc) begin
         w_cmd_next   = pw_wdata;
         w_state_next = (pw_wdata == CMD_READ) ? ST_STAT : ST_OTHER;
      end else if (r_state == ST_STAT && usr_miso_ack) begin
         w_state_next = ST_DATA;
      end
   end

   // Only an ack removes a byte, so an aborted read never loses data that was not shifted out.
   always_comb begin
      w_pop   = (r_state == ST_DATA) && usr_miso_ack;
      w_flush = pw_end && (r_state == ST_OTHER) && (r_cmd == CMD_FLUSH);
      case (w_state_next)
         ST_STAT: w_miso_next = w_cmd_acc ? sat8(9'(w_level)) : r_miso;
         ST_DATA: w_miso_next = w_empty_next ? FILL : w_head_next;
         default: w_miso_next = FILL;
      endcase
   end

   assign usr_miso_data = r_miso;
   assign evt_ready     = w_ready;
   assign level         = w_level;

`ifdef SPI_EVT_IRQ_EN
   logic r_irq;
   always_ff @(posedge clk) begin
      if (rst)
         r_irq <= 1'b0;
      else
         r_irq <= ~w_empty_next;
   end
   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_evt_reader.sv
// Randomised scoreboard bench for spi_evt_reader against a queue-based model of the event FIFO.
// Build with SPI_EVT_IRQ_EN defined to also check the interrupt.
module tb_spi_evt_reader;
   localparam int         DEPTH = 16;
   localparam logic [7:0] FILL  = 8'hFF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pw_wdata = '0;
   logic       pw_wcmd = 1'b0;
   logic       pw_wstb = 1'b0;
   logic       pw_end = 1'b0;
   logic [7:0] usr_miso_data;
   logic       usr_miso_ack = 1'b0;
   logic [7:0] evt_data = '0;
   logic       evt_valid = 1'b0;
   logic       evt_ready;
   logic [4:0] level;
   logic       irq;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];   // expected MISO bytes, in slot order
   logic [7:0] model[$];   // reference FIFO contents
   int         phase = 0;  // 0 idle, 1 status slot pending, 2 data slots, 3 other command
   logic [7:0] last_cmd = '0;

   spi_evt_reader #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .pw_wdata      (pw_wdata),
      .pw_wcmd       (pw_wcmd),
      .pw_wstb       (pw_wstb),
      .pw_end        (pw_end),
      .usr_miso_data (usr_miso_data),
      .usr_miso_ack  (usr_miso_ack),
      .evt_data      (evt_data),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .level         (level),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   // Monitor: every acked slot is compared against the head of the scoreboard.
   always @(negedge clk) begin
      if (usr_miso_ack) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL miso_unexpected got=%02h required=none", usr_miso_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (usr_miso_data !== e) begin
               errors++;
               $display("FAIL miso_slot got=%02h required=%02h", usr_miso_data, e);
            end else begin
               $display("slot miso=%02h", usr_miso_data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   task automatic check_state(input string tag);
      int exp_irq;
`ifdef SPI_EVT_IRQ_EN
      exp_irq = (model.size() != 0) ? 1 : 0;
`else
      exp_irq = 0;
`endif
      cmp({tag, "_level"}, int'(level), model.size());
      cmp({tag, "_ready"}, int'(evt_ready), (model.size() < DEPTH) ? 1 : 0);
      cmp({tag, "_irq"}, int'(irq), exp_irq);
      if (phase == 0)
         cmp({tag, "_idle_miso"}, int'(usr_miso_data), int'(FILL));
      $display("state %s level=%0d ready=%0b irq=%0b", tag, level, evt_ready, irq);
   endtask

   task automatic push_byte(input logic [7:0] b);
      evt_data  = b;
      evt_valid = 1'b1;
      if (model.size() < DEPTH)
         model.push_back(b);
      $display("push %02h", b);
      step();
      evt_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] c);
      pw_wdata = c;
      pw_wcmd  = 1'b1;
      pw_wstb  = 1'b1;
      last_cmd = c;
      if (c == 8'hF5) begin
         exp_q.push_back((model.size() > 255) ? 8'hFF : 8'(model.size()));
         phase = 1;
      end else begin
         phase = 3;
      end
      $display("cmd %02h", c);
      step();
      pw_wstb = 1'b0;
      pw_wcmd = 1'b0;
   endtask

   task automatic slot(input bit with_push, input logic [7:0] b);
      bit acc;
      acc = (model.size() < DEPTH);
      if (phase == 1)
         phase = 2;
      else if (phase == 2)
         exp_q.push_back((model.size() > 0) ? model.pop_front() : FILL);
      else
         exp_q.push_back(FILL);
      if (with_push && acc)
         model.push_back(b);
      usr_miso_ack = 1'b1;
      if (with_push) begin
         evt_valid = 1'b1;
         evt_data  = b;
      end
      step();
      usr_miso_ack = 1'b0;
      evt_valid    = 1'b0;
      step();
      step();
   endtask

   task automatic end_txn(input bit with_push, input logic [7:0] b);
      if (phase == 3 && last_cmd == 8'hF6)
         model.delete();
      else if (with_push && model.size() < DEPTH)
         model.push_back(b);
      pw_end = 1'b1;
      if (with_push) begin
         evt_valid = 1'b1;
         evt_data  = b;
      end
      phase = 0;
      $display("end push=%0b", with_push);
      step();
      pw_end    = 1'b0;
      evt_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      model.delete();
      phase = 0;
      $display("reset");
   endtask

   initial begin
      do_reset();
      check_state("reset");

      // basic read
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      check_state("basic_pushed");
      send_cmd(8'hF5);
      for (int i = 0; i < 4; i++) slot(1'b0, 8'h00);
      end_txn(1'b0, 8'h00);
      check_state("basic_done");

      // underflow
      push_byte(8'hA5);
      send_cmd(8'hF5);
      for (int i = 0; i < 4; i++) slot(1'b0, 8'h00);
      end_txn(1'b0, 8'h00);
      check_state("underflow");

      // abort and resume
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      send_cmd(8'hF5);
      slot(1'b0, 8'h00); slot(1'b0, 8'h00);
      end_txn(1'b0, 8'h00);
      check_state("abort");
      send_cmd(8'hF5);
      for (int i = 0; i < 4; i++) slot(1'b0, 8'h00);
      end_txn(1'b0, 8'h00);
      check_state("resume");

      // full: 17 pushes with valid held
      for (int i = 0; i < 17; i++) begin
         cmp("full_ready", int'(evt_ready), (model.size() < DEPTH) ? 1 : 0);
         push_byte(8'(8'h40 + i));
      end
      check_state("full");
      send_cmd(8'hF5);
      slot(1'b0, 8'h00);
      slot(1'b1, 8'hE1);
      slot(1'b1, 8'hE2);
      end_txn(1'b0, 8'h00);
      check_state("full_read");

      // flush with a push on the flush cycle
      do_reset();
      for (int i = 0; i < 5; i++) push_byte(8'($urandom));
      check_state("flush_pre");
      send_cmd(8'hF6);
      slot(1'b0, 8'h00);
      end_txn(1'b1, 8'h77);
      check_state("flush");

      // reset mid-DATA, then irq on the next push
      push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
      send_cmd(8'hF5);
      slot(1'b0, 8'h00); slot(1'b0, 8'h00);
      do_reset();
      check_state("mid_reset");
      push_byte(8'h5A);
      check_state("irq_after_reset");

      // randomized traffic
      for (int it = 0; it < 60; it++) begin
         int op;
         op = $urandom_range(0, 4);
         case (op)
            0: begin
               int n;
               n = $urandom_range(1, 7);
               for (int k = 0; k < n; k++) push_byte(8'($urandom));
            end
            1: begin
               int n;
               n = $urandom_range(1, 6);
               send_cmd(8'hF5);
               for (int k = 0; k < n; k++) slot(1'b0, 8'h00);
               end_txn($urandom_range(0, 1) == 1, 8'($urandom));
            end
            2: begin
               logic [7:0] c;
               int n;
               c = ($urandom_range(0, 2) == 0) ? 8'hF6 : 8'($urandom);
               while (c == 8'hF5) c = 8'($urandom);
               n = $urandom_range(0, 2);
               send_cmd(c);
               for (int k = 0; k < n; k++) slot($urandom_range(0, 1) == 1, 8'($urandom));
               end_txn($urandom_range(0, 1) == 1, 8'($urandom));
            end
            3: begin
               int n;
               n = $urandom_range(1, 6);
               send_cmd(8'hF5);
               for (int k = 0; k < n; k++) slot($urandom_range(0, 1) == 1, 8'($urandom));
               end_txn(1'b0, 8'h00);
            end
            default: begin
               send_cmd(8'hF5);
               slot(1'b0, 8'h00);
               slot($urandom_range(0, 1) == 1, 8'($urandom));
               send_cmd(8'hF5);
               slot(1'b0, 8'h00);
               slot(1'b0, 8'h00);
               end_txn(1'b0, 8'h00);
            end
         endcase
         check_state("rand");
      end

      step();
      cmp("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_evt_reader.md
# spi_evt_reader

Host-readable event queue on the SPI device link: the read-direction counterpart to the write-decode logic that latches host commands such as the 0xF4 button-state write. FPGA-side logic pushes 8-bit event bytes into an internal FIFO. The host issues a read command. The block then answers on the MISO byte channel of `spi_dev_core`/`spi_dev_proto` with a status byte followed by queued bytes, and optionally raises an interrupt while data is pending.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `CMD_READ`, 8'hF5: command byte that starts a read.
- `CMD_FLUSH`, 8'hF6: command byte that empties the FIFO when the transaction ends.
- `FILL`, 8'hFF: byte returned on underflow and when idle.
- `clk` in 1: single system clock (48 MHz).
- `rst` in 1: synchronous, active-high reset.
- `pw_wdata` in 8: received byte from the protocol layer.
- `pw_wcmd` in 1: marks `pw_wdata` as the command byte.
- `pw_wstb` in 1: one-cycle strobe, `pw_wdata` valid.
- `pw_end` in 1: one-cycle pulse at end of transaction (CS rise).
- `usr_miso_data` out 8: byte offered for the next MISO slot.
- `usr_miso_ack` in 1: one-cycle pulse; the core consumed `usr_miso_data`.
- `evt_data` in 8: event byte to enqueue.
- `evt_valid` in 1: push request.
- `evt_ready` out 1: FIFO not full. A push is taken when `evt_valid & evt_ready`.
- `level` out clog2(DEPTH)+1: current FIFO occupancy.
- `irq` out 1: pending-data interrupt; see Configuration.

## Operation
- States: IDLE, STAT, DATA, OTHER.
- **IDLE:** `usr_miso_data = FILL`.
  - On `pw_wstb & pw_wcmd`, latch the command byte.
  - If the command is `CMD_READ`, go to STAT. Otherwise go to OTHER.
- **STAT:** `usr_miso_data` = `level` sampled at command acceptance, saturated to 8'hFF.
  - On `usr_miso_ack`, go to DATA.
- **DATA:** `usr_miso_data` = FIFO head, or `FILL` if the FIFO is empty.
  - On `usr_miso_ack` with the FIFO non-empty, pop.
  - On `usr_miso_ack` with the FIFO empty, do not pop. This is an underflow and FIFO state is unchanged.
- **OTHER:** ignore `usr_miso_ack`.
  - On `pw_end`, if the latched command is `CMD_FLUSH`, empty the FIFO.
- **Any state:** `pw_end` returns to IDLE.
  - A byte is removed only by an ack, so a read aborted by CS rise loses no un-shifted data.
- **Mid-transaction command:** a new `pw_wcmd` strobe without an intervening `pw_end` restarts decode from IDLE semantics.
- **Push:**
  - When full, `evt_ready = 0` and the push is dropped; the pusher must hold.
  - Push and pop in the same cycle: both happen, `level` is unchanged.
  - When empty, push plus an underflowed ack: the push happens and no pop.
- **Flush vs push:** if a push coincides with the flush cycle, the flush wins and the push is discarded.
- **Pointers:** wrap modulo DEPTH. `level` ranges 0..DEPTH.

## Timing
- **Reset values:**
  - State IDLE, FIFO empty.
  - `usr_miso_data = FILL`, `evt_ready = 1`, `level = 0`, `irq = 0`.
- **Registered outputs:** all outputs are registered.
  - `usr_miso_data` updates in the cycle after `pw_wcmd` or `usr_miso_ack`, and is stable until the next ack.
  - Acks are at least 8 SPI bit times apart, so 1 cycle is sufficient.
- **Push latency:** a push at cycle n is visible in `level`/`evt_ready` at n+1. If it lands in an empty FIFO while in DATA, it also appears on `usr_miso_data` at n+1.
- **STAT snapshot:** the STAT value excludes pushes that occur after command acceptance.
- **`rst` priority:** `rst` overrides everything. Reset mid-read returns to IDLE with the FIFO empty.

## Configuration
- **`SPI_EVT_IRQ_EN` defined:** `irq` is registered and equals `level != 0`.
  - Rises 1 cycle after the first push into an empty FIFO.
  - Falls 1 cycle after the pop or flush that empties it.
- **`SPI_EVT_IRQ_EN` undefined:** `irq` is tied to 0 and no irq logic is synthesized.

## Structure
- **Package `spi_evt_pkg`:** state enum (IDLE/STAT/DATA/OTHER) and default command constants 8'hF5/8'hF6.
- **Sub-module `fifo_sync`:** synchronous FIFO with push/pop/flush, head output, `level`, full and empty flags.
- **Top:** `spi_evt_reader` holds the command FSM and MISO mux.

## Test plan
- **Basic read:** push 0x11, 0x22, 0x33, then host read F5 + 4 slots.
  - MISO returns 0x03, 0x11, 0x22, 0x33. Level ends at 0.
- **Underflow:** push 0xA5, then read with 4 slots.
  - MISO returns 0x01, 0xA5, 0xFF, 0xFF. No extra pops, level 0.
- **Full:** DEPTH=16, push 17 bytes with `evt_valid` held.
  - `evt_ready` drops after the 16th push. Level 16. STAT byte 0x10.
- **Abort and resume:** read F5 with 2 slots, CS rise, then a second read.
  - First read returns 0x03, 0x11 (one pop).
  - Second read returns 0x02, 0x22, 0x33.
- **Flush:** F6 then `pw_end` with the FIFO at 5, plus a simultaneous push on the flush cycle.
  - Level 0, `irq` 0 one cycle later.
- **Reset and irq:** assert `rst` mid-DATA.
  - All outputs return to reset values.
  - With `SPI_EVT_IRQ_EN`, the next push drives `irq = 1` one cycle later.
